// File: rtl/cmd_launcher.sv
// Host command queue feeding a serial master FSM: DEPTH-entry FIFO, one-cycle start, gap after done.
// Optional: define CMD_TIMEOUT_EN to abort a command whose done does not arrive within TIMEOUT cycles.
module cmd_launcher #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned GAP_W   = 10,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cs,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [DATA_W-1:0]      writedatain,
    input  logic [ADDR_W-1:0]      addressin,
    input  logic [GAP_W-1:0]       gap,
    input  logic                   done,
    input  logic                   hold,
    output logic                   start,
    output logic                   rw,
    output logic [DATA_W-1:0]      writedataout,
    output logic [ADDR_W-1:0]      addressout,
    output logic                   stop,
    output logic                   busy,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ovf,
    output logic                   timeout
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GAP
    } state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("cmd_launcher: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    state_t           state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    entry_t           mem_q [DEPTH];
    entry_t           out_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             req_q, start_q, stop_q, ovf_q;
    logic             req, push, pop, accept, full_w;

    // One push per request assertion, however long cs stays high.
    assign req    = cs & (wr | rd);
    assign push   = req & ~req_q;
    assign full_w = (count_q == CNT_W'(DEPTH));
    assign accept = push & (~full_w | pop);

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              wait_expired, tmo_d, tmo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     wait_cnt_q <= '0;
        else if (state_q != ST_WAIT) wait_cnt_q <= '0;
        else                         wait_cnt_q <= wait_cnt_q + 1'b1;
    end

    assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));
`endif

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        pop       = 1'b0;
`ifdef CMD_TIMEOUT_EN
        tmo_d     = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    if (gap == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap;
                        state_d   = ST_GAP;
                    end
                end
`ifdef CMD_TIMEOUT_EN
                else if (wait_expired) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q == GAP_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            req_q     <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            req_q     <= req;
            start_q   <= pop;
            stop_q    <= hold;
            ovf_q     <= push & full_w & ~pop;
            if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                out_q    <= mem_q[rd_ptr_q];
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: FIFO storage is not reset; the pointers and count decide which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= '{rw: rd, addr: addressin, data: writedatain};
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= 1'b0;
        else     tmo_q <= tmo_d;
    end
    assign timeout = tmo_q;
`else
    assign timeout = 1'b0;
`endif

    assign start        = start_q;
    assign rw           = out_q.rw;
    assign writedataout = out_q.data;
    assign addressout   = out_q.addr;
    assign stop         = stop_q;
    assign busy         = (state_q != ST_IDLE) | (count_q != '0);
    assign full         = full_w;
    assign count        = count_q;
    assign ovf          = ovf_q;

endmodule
